// File: rtl/div_repsub.sv
// rtl/div_repsub.sv - sequential unsigned divider by repeated subtraction
// Optional feature macro: DIV_DBZ_FLAG_EN (all-ones quotient and sticky div_by_zero flag on zero divisor)
module div_repsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOADB = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] divisor;
  logic             div_zero;
  logic             rem_ge;

  assign div_zero = (divisor == '0);
  assign rem_ge   = (remainder >= divisor);

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = LOADB;
        end
      end
      LOADB: begin
        state_next = RUN;
      end
      RUN: begin
        // A zero divisor exits at once so the FSM can never spin forever
        if (div_zero || !rem_ge) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, then one subtract/increment per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      divisor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remainder <= data_in;
            quotient  <= '0;
          end
        end
        LOADB: begin
          divisor <= data_in;
        end
        RUN: begin
          if (div_zero) begin
`ifdef DIV_DBZ_FLAG_EN
            quotient <= '1;
`endif
          end else if (rem_ge) begin
            remainder <= remainder - divisor;
            quotient  <= quotient + ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIV_DBZ_FLAG_EN
  logic dbz_flag;

  // Sticky zero-divisor flag, cleared only by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_flag <= 1'b0;
    end else if (state == IDLE && start) begin
      dbz_flag <= 1'b0;
    end else if (state == RUN && div_zero) begin
      dbz_flag <= 1'b1;
    end
  end

  assign div_by_zero = dbz_flag;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
